// File: rtl/logs_pkg.sv
// Shared definitions for the logistic-map iteration engine.
package logs_pkg;

  localparam int unsigned FRAC_DEF = 8;
  localparam int unsigned ONE      = 1 << FRAC_DEF;
  localparam int unsigned SEED_DEF = 1 << (FRAC_DEF - 1);

  typedef enum logic [1:0] {
    MUL1 = 2'd0,
    MUL2 = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/logs_serial_mul.sv
// Serial LSB-first shift-add unsigned multiplier; start also performs the first bit step.
module logs_serial_mul #(
  parameter int unsigned AW = 9,
  parameter int unsigned BW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             done,
  output logic [AW+BW-1:0] product
);

  localparam int unsigned PW = AW + BW;
  localparam int unsigned NW = $clog2(BW + 1);

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] a_sh_q, a_sh_d;
  logic [BW-1:0] b_sh_q, b_sh_d;
  logic [NW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    if (start) begin
      acc_d  = b[0] ? PW'(a) : '0;
      a_sh_d = PW'(a) << 1;
      b_sh_d = b >> 1;
      cnt_d  = NW'(BW - 1);
    end else if (cnt_q != '0) begin
      if (b_sh_q[0]) begin
        acc_d = acc_q + a_sh_q;
      end
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q - NW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done    = (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/logs_map_engine.sv
// Logistic map x' = r*x*(1-x) in fixed point, one iteration every ITER_LEN clocks.
module logs_map_engine
  import logs_pkg::*;
#(
  parameter int unsigned FRAC     = FRAC_DEF,
  parameter int unsigned ITER_LEN = 100,
  parameter int unsigned SEED     = 1 << (FRAC - 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FRAC+1:0] r,
  output logic [FRAC-1:0] x,
  output logic            next_ready,
  output logic            reseeded
);

  localparam int unsigned CW = $clog2(ITER_LEN);
  localparam int unsigned AW = FRAC + 1;
  localparam int unsigned BW = FRAC + 2;
  localparam int unsigned PW = AW + BW;

  if (ITER_LEN < 2 * FRAC + 4) begin : g_bad_iter_len
    $error("logs_map_engine: ITER_LEN must be >= 2*FRAC+4");
  end
  if (SEED == 0) begin : g_bad_seed
    $error("logs_map_engine: SEED must be nonzero");
  end

  logic [CW-1:0]   c_q, c_d;
  state_e          state_q, state_d;
  logic [FRAC+1:0] r_lat_q, r_lat_d;
  logic [FRAC-1:0] x_q, x_d;
  logic            nr_q, nr_d;
  logic            rs_q, rs_d;

  logic            commit;
  logic            mul_start;
  logic [AW-1:0]   mul_a;
  logic [BW-1:0]   mul_b;
  logic            mul_done;
  logic [PW-1:0]   prod;
  logic            sat;
  logic [FRAC-1:0] res;
  logic            unused_bits;

  logs_serial_mul #(
    .AW (AW),
    .BW (BW)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (prod)
  );

  assign unused_bits = ^{mul_done, prod[FRAC-1:0]};

  always_comb begin
    commit  = (c_q == CW'(ITER_LEN - 1));
    c_d     = commit ? '0 : c_q + CW'(1);
    r_lat_d = (c_q == CW'(1)) ? r : r_lat_q;

    state_d = state_q;
    case (state_q)
      MUL1:    if (c_q == CW'(FRAC - 1))     state_d = MUL2;
      MUL2:    if (c_q == CW'(2 * FRAC + 1)) state_d = WAIT;
      WAIT:    if (commit)                   state_d = MUL1;
      default:                               state_d = MUL1;
    endcase

    // The multiplier is restarted at c=0 for q and at c=FRAC for p;
    // its product register carries q into the second pass.
    mul_start = 1'b0;
    mul_a     = {1'b1, {FRAC{1'b0}}} - {1'b0, x_q};
    mul_b     = {2'b00, x_q};
    if (state_q == MUL1) begin
      mul_start = (c_q == '0);
    end else begin
      mul_a     = prod[2*FRAC:FRAC];
      mul_b     = r_lat_q;
      mul_start = (state_q == MUL2) && (c_q == CW'(FRAC));
    end

    sat = |prod[PW-1:2*FRAC];
    res = sat ? '1 : prod[2*FRAC-1:FRAC];

    x_d  = x_q;
    nr_d = 1'b0;
    rs_d = 1'b0;
    if (commit) begin
      nr_d = 1'b1;
      if (res == '0) begin
        x_d  = FRAC'(SEED);
        rs_d = 1'b1;
      end else begin
        x_d = res;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q     <= '0;
      state_q <= MUL1;
      r_lat_q <= '0;
      x_q     <= FRAC'(SEED);
      nr_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      c_q     <= c_d;
      state_q <= state_d;
      r_lat_q <= r_lat_d;
      x_q     <= x_d;
      nr_q    <= nr_d;
      rs_q    <= rs_d;
    end
  end

  assign x          = x_q;
  assign next_ready = nr_q;
  assign reseeded   = rs_q;

endmodule
